mem_access_stage: RTL and testbench

Memory-access pipeline stage of the 64-bit CPU, sitting between execute and write-back. It takes the EX/MEM bundle, performs one data-memory load or store over a req/ack handshake, and registers the MEM/WB bundle (register number, loaded data, ALU result, MemToReg, RegWrite) that the write-back stage consumes directly. While a memory transaction is outstanding it stalls upstream. Misaligned accesses and timeouts are reported as faults.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_wb_reg.sv | 52 +++++
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 64-bit CPU pipeline: stage states, fault codes
// and architectural constants.
package cpu_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } stage_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

    localparam int XZR     = 31;
    localparam int INSTR_W = 32;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Fields load on i_load; otherwise the valid and
// RegWrite strobes clear while the data fields hold.
import cpu_pkg::*;

module mem_wb_reg #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = XZR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [4:0]        i_reg,
    input  logic [DATA_W-1:0] i_loaded_data,
    input  logic [DATA_W-1:0] i_results,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_write,
    output logic              o_valid,
    output logic [4:0]        o_reg,
    output logic [DATA_W-1:0] o_loaded_data,
    output logic [DATA_W-1:0] o_results,
    output logic              o_mem_to_reg,
    output logic              o_reg_write
);

    logic w_reg_write_masked;

    // XZR is never written, and an invalid slot never writes anything.
    assign w_reg_write_masked = i_valid && i_reg_write && (i_reg != 5'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid       <= 1'b0;
            o_reg         <= '0;
            o_loaded_data <= '0;
            o_results     <= '0;
            o_mem_to_reg  <= 1'b0;
            o_reg_write   <= 1'b0;
        end else if (i_load) begin
            o_valid       <= i_valid;
            o_reg         <= i_reg;
            o_loaded_data <= i_loaded_data;
            o_results     <= i_results;
            o_mem_to_reg  <= i_mem_to_reg;
            o_reg_write   <= w_reg_write_masked;
        end else begin
            o_valid     <= 1'b0;
            o_reg_write <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one data-memory load/store per bundle over req/ack,
// with misalignment and timeout faults, feeding the MEM/WB register.
import cpu_pkg::*;

module mem_access_stage #(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ZERO_REG       = XZR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_reg_write,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] wb_loaded_data,
    output logic [DATA_W-1:0] wb_results,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic              mem_fault,
    output logic [1:0]        fault_code
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    stage_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_reg;
    logic             r_mem_to_reg;
    logic             r_reg_write;
    logic             r_is_load;

    logic              w_mem_op;
    logic              w_misaligned;
    logic              w_timeout;
    logic              w_wb_load;
    logic              w_wb_valid;
    logic [4:0]        w_wb_reg;
    logic [DATA_W-1:0] w_wb_loaded;
    logic [DATA_W-1:0] w_wb_results;
    logic              w_wb_mem_to_reg;
    logic              w_wb_reg_write;

    assign w_mem_op     = ex_mem_read | ex_mem_write;
    assign w_misaligned = |ex_alu_result[2:0];
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mem_stall    = (r_state == ACCESS);

    // Selects what the MEM/WB register captures this cycle.
    always_comb begin
        w_wb_load       = 1'b0;
        w_wb_valid      = 1'b0;
        w_wb_reg        = ex_reg;
        w_wb_loaded     = '0;
        w_wb_results    = ex_alu_result;
        w_wb_mem_to_reg = ex_mem_to_reg;
        w_wb_reg_write  = ex_reg_write;
        case (r_state)
            IDLE: begin
                if (ex_valid && (!w_mem_op || w_misaligned)) begin
                    w_wb_load  = 1'b1;
                    w_wb_valid = 1'b1;
                    if (w_mem_op) begin
                        w_wb_reg_write = 1'b0;
                    end
                end
            end
            ACCESS: begin
                w_wb_reg        = r_reg;
                w_wb_results    = dmem_addr;
                w_wb_mem_to_reg = r_mem_to_reg;
                w_wb_reg_write  = r_reg_write;
                if (dmem_ack) begin
                    w_wb_load   = 1'b1;
                    w_wb_valid  = 1'b1;
                    w_wb_loaded = r_is_load ? dmem_rdata : '0;
                end else if (w_timeout) begin
                    w_wb_load      = 1'b1;
                    w_wb_valid     = 1'b1;
                    w_wb_reg_write = 1'b0;
                end
            end
            default: begin
                w_wb_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_reg        <= '0;
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_is_load    <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            mem_fault    <= 1'b0;
            fault_code   <= FAULT_NONE;
        end else begin
            mem_fault  <= 1'b0;
            fault_code <= FAULT_NONE;
            case (r_state)
                IDLE: begin
                    if (ex_valid && w_mem_op) begin
                        if (w_misaligned) begin
                            mem_fault  <= 1'b1;
                            fault_code <= FAULT_MISALIGN;
                        end else begin
                            r_state      <= ACCESS;
                            r_cnt        <= '0;
                            r_reg        <= ex_reg;
                            r_mem_to_reg <= ex_mem_to_reg;
                            r_reg_write  <= ex_reg_write;
                            r_is_load    <= ex_mem_read & ~ex_mem_write;
                            dmem_req     <= 1'b1;
                            dmem_we      <= ex_mem_write;
                            dmem_addr    <= ex_alu_result;
                            dmem_wdata   <= ex_store_data;
                        end
                    end
                end
                ACCESS: begin
                    // An ack on the limit cycle takes priority over the timeout.
                    if (dmem_ack) begin
                        r_state  <= IDLE;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        mem_fault  <= 1'b1;
                        fault_code <= FAULT_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .DATA_W  (DATA_W),
        .ZERO_REG(ZERO_REG)
    ) u_mem_wb_reg (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_wb_load),
        .i_valid      (w_wb_valid),
        .i_reg        (w_wb_reg),
        .i_loaded_data(w_wb_loaded),
        .i_results    (w_wb_results),
        .i_mem_to_reg (w_wb_mem_to_reg),
        .i_reg_write  (w_wb_reg_write),
        .o_valid      (wb_valid),
        .o_reg        (wb_reg),
        .o_loaded_data(wb_loaded_data),
        .o_results    (wb_results),
        .o_mem_to_reg (wb_mem_to_reg),
        .o_reg_write  (wb_reg_write)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table of single-cycle bundles
// plus hand-written load, store, timeout and reset sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_reg;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [63:0] wb_loaded_data;
    logic [63:0] wb_results;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic        mem_fault;
    logic [1:0]  fault_code;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W        (64),
        .TIMEOUT_CYCLES(16),
        .ZERO_REG      (31)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_reg        (ex_reg),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .wb_loaded_data(wb_loaded_data),
        .wb_results    (wb_results),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .mem_fault     (mem_fault),
        .fault_code    (fault_code)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rg;
        logic [63:0] alu;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        rw;
        logic        e_valid;
        logic [4:0]  e_reg;
        logic [63:0] e_results;
        logic        e_rw;
        logic        e_fault;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rg, input logic [63:0] alu,
                         input logic [63:0] sd, input logic rd, input logic wr,
                         input logic m2r, input logic rw);
        ex_valid      = v;
        ex_reg        = rg;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_mem_to_reg = m2r;
        ex_reg_write  = rw;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int stall_cnt;
        logic ok;

        //           v  reg    alu          rd wr m2r rw | valid reg    results      rw fault code
        vecs[0] = '{1'b1, 5'd5,  64'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  64'h1234, 1'b1, 1'b0, 2'd0};
        vecs[1] = '{1'b1, 5'd31, 64'h77,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd31, 64'h77,   1'b0, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 5'd3,  64'h4000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  64'h4000, 1'b0, 1'b0, 2'd0};
        vecs[3] = '{1'b1, 5'd4,  64'h103,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd4,  64'h103,  1'b0, 1'b1, 2'd1};
        vecs[4] = '{1'b1, 5'd8,  64'h20C,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  64'h20C,  1'b0, 1'b1, 2'd1};
        vecs[5] = '{1'b1, 5'd2,  64'h1,    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2,  64'h1,    1'b0, 1'b1, 2'd1};
        vecs[6] = '{1'b0, 5'd9,  64'h999,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2,  64'h1,    1'b0, 1'b0, 2'd0};

        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 64'd0;
        idle();
        step();
        step();

        // Reset state
        chk("rst_stall", {63'd0, mem_stall}, 64'd0);
        chk("rst_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        chk("rst_wb_results", wb_results, 64'd0);
        chk("rst_fault", {62'd0, fault_code}, 64'd0);
        rst = 1'b0;
        step();

        // Single-cycle bundles: ALU ops, XZR masking, misaligned ops, idle hold
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].valid, vecs[i].rg, vecs[i].alu, 64'hAA, vecs[i].rd,
                  vecs[i].wr, vecs[i].m2r, vecs[i].rw);
            step();
            chk($sformatf("v%0d_valid", i), {63'd0, wb_valid}, {63'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_reg", i), {59'd0, wb_reg}, {59'd0, vecs[i].e_reg});
            chk($sformatf("v%0d_results", i), wb_results, vecs[i].e_results);
            chk($sformatf("v%0d_rw", i), {63'd0, wb_reg_write}, {63'd0, vecs[i].e_rw});
            chk($sformatf("v%0d_fault", i), {63'd0, mem_fault}, {63'd0, vecs[i].e_fault});
            chk($sformatf("v%0d_code", i), {62'd0, fault_code}, {62'd0, vecs[i].e_code});
            chk($sformatf("v%0d_req", i), {62'd0, dmem_req, mem_stall}, 64'd0);
            chk($sformatf("v%0d_loaded", i), wb_loaded_data, 64'd0);
            idle();
            step();
            chk($sformatf("v%0d_pulse", i), {61'd0, wb_valid, wb_reg_write, mem_fault}, 64'd0);
            chk($sformatf("v%0d_code_clr", i), {62'd0, fault_code}, 64'd0);
        end

        // Load with ack in the third request cycle
        drive(1'b1, 5'd7, 64'h100, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        stall_cnt = 0;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (mem_stall) stall_cnt++;
            if (!(dmem_req && !dmem_we && dmem_addr == 64'h100)) ok = 1'b0;
            if (i == 2) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 64'hDEADBEEF;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("ld_req_stable", {63'd0, ok}, 64'd1);
        chk("ld_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("ld_stall_clr", {62'd0, mem_stall, dmem_req}, 64'd0);
        chk("ld_wb_valid", {63'd0, wb_valid}, 64'd1);
        chk("ld_loaded", wb_loaded_data, 64'hDEADBEEF);
        chk("ld_reg", {59'd0, wb_reg}, 64'd7);
        chk("ld_m2r_rw", {62'd0, wb_mem_to_reg, wb_reg_write}, 64'd3);
        chk("ld_fault", {63'd0, mem_fault}, 64'd0);
        step();
        chk("ld_pulse", {63'd0, wb_valid}, 64'd0);

        // Store: rdata on the bus must not reach loaded data
        drive(1'b1, 5'd9, 64'h208, 64'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (!(dmem_req && dmem_we && dmem_addr == 64'h208 && dmem_wdata == 64'h55)) ok = 1'b0;
            if (i == 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 64'hFFFF;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("st_bus_stable", {63'd0, ok}, 64'd1);
        chk("st_wb_valid", {63'd0, wb_valid}, 64'd1);
        chk("st_rw", {63'd0, wb_reg_write}, 64'd0);
        chk("st_loaded", wb_loaded_data, 64'd0);
        chk("st_req_drop", {63'd0, dmem_req}, 64'd0);
        step();

        // Read and write both set behave as a store
        drive(1'b1, 5'd11, 64'h10, 64'h99, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        chk("rw_both_we", {62'd0, dmem_req, dmem_we}, 64'd3);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h1234_5678;
        step();
        dmem_ack = 1'b0;
        chk("rw_both_loaded", wb_loaded_data, 64'd0);
        chk("rw_both_valid", {63'd0, wb_valid}, 64'd1);
        step();

        // Timeout: no ack at all
        drive(1'b1, 5'd10, 64'h300, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            step();
        end
        chk("to_req_cycles", 64'(n), 64'd16);
        chk("to_fault", {63'd0, mem_fault}, 64'd1);
        chk("to_code", {62'd0, fault_code}, 64'd2);
        chk("to_wb", {62'd0, wb_valid, wb_reg_write}, 64'd2);
        chk("to_stall", {63'd0, mem_stall}, 64'd0);
        step();
        chk("to_fault_clr", {61'd0, mem_fault, fault_code}, 64'd0);

        // Ack in the final wait cycle wins over the timeout
        drive(1'b1, 5'd12, 64'h308, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 64'hCAFE;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("late_ack_fault", {61'd0, mem_fault, fault_code}, 64'd0);
        chk("late_ack_wb", {62'd0, wb_valid, wb_reg_write}, 64'd3);
        chk("late_ack_data", wb_loaded_data, 64'hCAFE);
        step();

        // Reset in the second ACCESS cycle; the following ack is ignored
        drive(1'b1, 5'd13, 64'h400, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_req", {62'd0, dmem_req, mem_stall}, 64'd0);
        chk("mrst_wb", {61'd0, wb_valid, wb_reg_write, wb_mem_to_reg}, 64'd0);
        chk("mrst_wb_data", wb_loaded_data | wb_results | {59'd0, wb_reg}, 64'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD;
        step();
        dmem_ack = 1'b0;
        chk("mrst_ack_ignored", {61'd0, wb_valid, mem_stall, dmem_req}, 64'd0);
        chk("mrst_ack_data", wb_loaded_data, 64'd0);
        drive(1'b1, 5'd6, 64'hABC0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        chk("mrst_alu_wb", {62'd0, wb_valid, wb_reg_write}, 64'd3);
        chk("mrst_alu_res", wb_results, 64'hABC0);
        chk("mrst_alu_reg", {59'd0, wb_reg}, 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
